// File: rtl/rle_decoder.sv
// ---------------------------------------------------------------------------
// rle_decoder
// Run-length decoder for EEG sample streams. (value, count) pairs are queued
// in a small pair FIFO. Each pair is expanded into 'count' copies of the
// signed sample. The sample values are passed through unchanged and are never
// used in arithmetic.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   in_valid      pair present on in_value/in_count
//   in_ready      decoder can accept a pair this cycle (registered, = !full)
//   in_value      signed run value (DATA_W)
//   in_count      run length (CNT_W); 0 is illegal and the pair is discarded
//   out_valid     out_sample valid
//   out_ready     downstream accepts sample this cycle
//   out_sample    signed decoded sample (DATA_W)
//   out_last      out_sample is the final copy of its run
//   zero_run_err  1-cycle pulse when a zero-count pair is discarded
// ---------------------------------------------------------------------------
module rle_decoder #(
  parameter int DATA_W     = 9,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_last,
  output logic              zero_run_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The pointers carry one extra wrap bit. The queue is full when the wrap
  // bits differ and the index bits match.
  function automatic logic ptr_full(input logic [PTR_W:0] wr, input logic [PTR_W:0] rd);
    return (wr[PTR_W] != rd[PTR_W]) && (wr[PTR_W-1:0] == rd[PTR_W-1:0]);
  endfunction

  logic [DATA_W-1:0] fifo_value_r [FIFO_DEPTH];
  logic [CNT_W-1:0]  fifo_count_r [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_r;
  logic [PTR_W:0]    rd_ptr_r;
  logic [PTR_W:0]    wr_ptr_n_s;
  logic [PTR_W:0]    rd_ptr_n_s;
  logic              in_ready_r;

  state_t            state_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [DATA_W-1:0] sample_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              zero_err_r;

  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              fire_s;
  logic              head_zero_s;
  logic [DATA_W-1:0] head_value_s;
  logic [CNT_W-1:0]  head_count_s;

  // FIFO status, handshakes and pop decision for the current cycle
  always_comb begin
    empty_s      = (wr_ptr_r == rd_ptr_r);
    head_value_s = fifo_value_r[rd_ptr_r[PTR_W-1:0]];
    head_count_s = fifo_count_r[rd_ptr_r[PTR_W-1:0]];
    head_zero_s  = (head_count_s == CNT_ZERO);
    // in_ready_r is registered, so a same-cycle pop never opens a full queue
    push_s       = in_valid && in_ready_r;
    fire_s       = out_valid_r && out_ready;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: pop_s = !empty_s;
      // Chain the next run onto the last copy without a bubble. A zero-count
      // head is left in place and is discarded from IDLE.
      RUN: begin
        if (fire_s && (remaining_r == CNT_ONE) && !empty_s && !head_zero_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: pop_s = 1'b0;
    endcase
    wr_ptr_n_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_n_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  end

  // Pair storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_value_r[wr_ptr_r[PTR_W-1:0]] <= in_value;
      fifo_count_r[wr_ptr_r[PTR_W-1:0]] <= in_count;
    end
  end

  // Pointer update and registered ready derived from next occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {(PTR_W+1){1'b0}};
      rd_ptr_r   <= {(PTR_W+1){1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      wr_ptr_r   <= wr_ptr_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      in_ready_r <= !ptr_full(wr_ptr_n_s, rd_ptr_n_s);
    end
  end

  // Expansion FSM with registered sample-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= CNT_ZERO;
      sample_r    <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      zero_err_r  <= 1'b0;
    end else begin
      zero_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            if (head_zero_s) begin
              zero_err_r <= 1'b1;
            end else begin
              sample_r    <= head_value_s;
              remaining_r <= head_count_s;
              out_valid_r <= 1'b1;
              out_last_r  <= (head_count_s == CNT_ONE);
              state_r     <= RUN;
            end
          end
        end
        RUN: begin
          if (fire_s) begin
            if (remaining_r == CNT_ONE) begin
              if (pop_s) begin
                sample_r    <= head_value_s;
                remaining_r <= head_count_s;
                out_last_r  <= (head_count_s == CNT_ONE);
              end else begin
                remaining_r <= CNT_ZERO;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                state_r     <= IDLE;
              end
            end else begin
              remaining_r <= remaining_r - CNT_ONE;
              out_last_r  <= (remaining_r == CNT_TWO);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_sample   = sample_r;
  assign out_last     = out_last_r;
  assign zero_run_err = zero_err_r;

endmodule

// File: tb/tb_rle_decoder.sv
module tb_rle_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_value;
  logic [7:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sample;
  logic       out_last;
  logic       zero_run_err;

  rle_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_last(out_last), .zero_run_err(zero_run_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Pairs waiting to be offered, and the expanded expected sample stream
  logic [8:0] sq_v[$];
  logic [7:0] sq_c[$];
  logic [8:0] exp_s[$];
  bit         exp_l[$];

  int zero_exp, zero_seen, samples_seen, accepted;
  int ready_mode;   // 0 always ready, 1 stalled, 2 random
  int gap_pct;
  int first_valid_cyc, last_fire_cyc, last_accept_cyc;
  bit         stall_prev;
  logic [8:0] stall_s;
  logic       stall_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [8:0] v, input logic [7:0] c);
    sq_v.push_back(v);
    sq_c.push_back(c);
  endtask

  task automatic start_test(input int rmode, input int gap);
    ready_mode = rmode;
    gap_pct = gap;
    zero_exp = 0; zero_seen = 0; samples_seen = 0; accepted = 0;
    first_valid_cyc = -1; last_fire_cyc = -1; last_accept_cyc = -1;
  endtask

  // One cycle: drive at the falling edge, check the registered outputs, and
  // note which handshakes the next rising edge will complete.
  task automatic do_cycle();
    @(negedge clk);
    if (sq_v.size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
      in_valid = 1'b1; in_value = sq_v[0]; in_count = sq_c[0];
    end else begin
      in_valid = 1'b0; in_value = 9'($urandom); in_count = 8'($urandom);
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(1, 0));
    endcase
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sample", 32'(out_sample), 32'(stall_s));
      chk("stall_last", 32'(out_last), 32'(stall_l));
    end
    if (zero_run_err) zero_seen++;
    if (out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_s.size() == 0) begin
        chk("unexpected_sample", 32'd1, 32'd0);
      end else begin
        chk("sample", 32'(out_sample), 32'(exp_s[0]));
        chk("last", 32'(out_last), 32'(exp_l[0]));
        if (out_ready) begin
          exp_s.pop_front();
          exp_l.pop_front();
        end
      end
      if (out_ready) begin
        samples_seen++;
        last_fire_cyc = cyc;
      end
    end else begin
      chk("last_when_idle", 32'(out_last), 32'd0);
    end
    stall_prev = out_valid && !out_ready;
    stall_s = out_sample;
    stall_l = out_last;
    if (in_valid && in_ready) begin
      accepted++;
      last_accept_cyc = cyc;
      if (sq_c[0] == 8'd0) begin
        zero_exp++;
      end else begin
        for (int i = 1; i <= int'(sq_c[0]); i++) begin
          exp_s.push_back(sq_v[0]);
          exp_l.push_back(i == int'(sq_c[0]));
        end
      end
      sq_v.pop_front();
      sq_c.pop_front();
    end
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sq_v.size() > 0 || exp_s.size() > 0 || out_valid) && n < budget) begin
      do_cycle();
      n++;
    end
    chk({tag, "_drained"}, 32'(sq_v.size() + exp_s.size()), 32'd0);
    // Leave time for trailing zero-count pairs to be discarded
    for (int i = 0; i < 6; i++) do_cycle();
    chk({tag, "_zero_err"}, 32'(zero_seen), 32'(zero_exp));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_value = 9'd0; in_count = 8'd0; out_ready = 1'b0;
    stall_prev = 1'b0;
    start_test(0, 0);
    #23;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_zero_err", 32'(zero_run_err), 32'd0);

    // T1: (-5,3), check the latency from acceptance to first sample
    start_test(0, 0);
    send(9'h1FB, 8'd3);
    drain("t1", 50);
    chk("t1_samples", 32'(samples_seen), 32'd3);
    chk("t1_latency", 32'(first_valid_cyc - last_accept_cyc), 32'd2);

    // T2: back-to-back runs without bubbles
    start_test(0, 0);
    send(9'd100, 8'd1);
    send(9'd255, 8'd2);
    send(9'h100, 8'd1);
    drain("t2", 50);
    chk("t2_samples", 32'(samples_seen), 32'd4);
    chk("t2_no_bubble", 32'(last_fire_cyc - first_valid_cyc), 32'd3);

    // T3: a zero-count pair is discarded and flagged
    start_test(0, 0);
    send(9'd7, 8'd0);
    send(9'd8, 8'd2);
    drain("t3", 50);
    chk("t3_samples", 32'(samples_seen), 32'd2);
    chk("t3_zero_pulses", 32'(zero_seen), 32'd1);

    // T4: stalled output fills FIFO, then releases in order
    start_test(1, 0);
    for (int i = 0; i < 6; i++) send(9'(i * 37 + 3), 8'(i + 1));
    for (int i = 0; i < 12; i++) do_cycle();
    chk("t4_accepted", 32'(accepted), 32'd5);
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    ready_mode = 0;
    drain("t4", 100);
    chk("t4_samples", 32'(samples_seen), 32'd21);

    // T5: maximum run length
    start_test(0, 0);
    send(9'd1, 8'd255);
    drain("t5", 400);
    chk("t5_samples", 32'(samples_seen), 32'd255);

    // T6: asynchronous reset in the middle of a run
    start_test(0, 0);
    send(9'd3, 8'd10);
    for (int n = 0; n < 40 && samples_seen < 4; n++) do_cycle();
    chk("t6_reached", 32'(samples_seen), 32'd4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_sample", 32'(out_sample), 32'd0);
    chk("t6_async_last", 32'(out_last), 32'd0);
    sq_v.delete(); sq_c.delete(); exp_s.delete(); exp_l.delete();
    stall_prev = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_test(0, 0);
    for (int i = 0; i < 16; i++) do_cycle();
    chk("t6_no_residual", 32'(samples_seen), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    send(9'h1F0, 8'd2);
    drain("t6_post", 50);
    chk("t6_post_samples", 32'(samples_seen), 32'd2);

    // Random pairs with random gaps and backpressure
    start_test(2, 30);
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(9, 0);
      if (r == 0)      c = 8'd0;
      else if (r == 9) c = 8'($urandom_range(255, 10));
      else             c = 8'(r);
      send(9'($urandom), c);
    end
    drain("rand", 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
